// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8 data bits, LSB first, 1 stop bit).
// The input is double-flopped; each bit is sampled three times around its middle
// and resolved by majority vote.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop
// (sense set by PARITY_ODD). Without it the frame is 10 bits and parity_err stays 0.
// Consumer handshake: recv_en is a one-cycle strobe with recv_data valid in the
// same cycle; there is no ready/backpressure, so the consumer must capture on
// recv_en. frame_err and parity_err are one-cycle strobes in that same slot.
module uart_rx #(
  parameter int CLK_FRE    = 50,
  parameter int UART_RATE  = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] recv_data,
  output logic       recv_en,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BIT_CNT = CLK_FRE * 1_000_000 / UART_RATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_HM1  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(HALF);
  localparam logic [CW-1:0] CNT_HP1  = CW'(HALF + 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam logic PAR_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state, state_next;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp_a, smp_b;
  logic          par_bad;

  logic falling, cnt_last, at_dec, maj;
  logic cnt_clr, strobe_ok, strobe_ferr;

  assign falling  = rx_d & ~rx_s2;
  assign cnt_last = (cnt == CNT_LAST);
  assign at_dec   = (cnt == CNT_HP1);
  assign maj      = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);

  // Synchroniser plus one delay flop for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_pin;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and end-of-frame decisions.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    strobe_ok   = 1'b0;
    strobe_ferr = 1'b0;
    case (state)
      S_IDLE: begin
        if (falling) begin
          state_next = S_START;
          cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        if (at_dec && maj) begin
          state_next = S_IDLE;              // glitch, not a real start bit
        end else if (cnt_last) begin
          state_next = S_DATA;
          cnt_clr    = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_clr = 1'b1;
          if (bit_idx == 3'd7) state_next = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          state_next = S_STOP;
          cnt_clr    = 1'b1;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so the next start edge is never missed.
        if (at_dec) begin
          if (maj) begin
            state_next = S_IDLE;
            strobe_ok  = 1'b1;
          end else begin
            state_next  = S_BREAK;
            strobe_ferr = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s2) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit-period counter; held at zero while idle or in break.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr || state_next == S_IDLE || state == S_BREAK) cnt <= '0;
    else                                                            cnt <= cnt + 1'b1;
  end

  // Mid-bit samples, data shift register, bit index and parity check.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_a   <= 1'b1;
      smp_b   <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      par_bad <= 1'b0;
    end else begin
      if (cnt == CNT_HM1) smp_a <= rx_s2;
      if (cnt == CNT_H)   smp_b <= rx_s2;
      if (state == S_DATA && at_dec) shreg <= {maj, shreg[7:1]};
      if (state != S_DATA)   bit_idx <= '0;
      else if (cnt_last)     bit_idx <= bit_idx + 1'b1;
      if (state == S_PARITY && at_dec) par_bad <= maj ^ (^shreg) ^ PAR_SENSE;
    end
  end

  // Registered outputs: strobes land in the cycle after the stop decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      recv_data  <= '0;
      recv_en    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      recv_en    <= strobe_ok;
      frame_err  <= strobe_ferr;
      parity_err <= strobe_ok & par_bad & PAR_EN;
      busy       <= (state_next != S_IDLE);
      if (strobe_ok) recv_data <= shreg;
    end
  end

endmodule
